// File: rtl/lock_sequencer.sv
// Lock state machine shared by the UART and keypad command sources: servo position,
// settle/hold timing, failed-authentication lockout and buzzer (beeps and alarm).
module lock_sequencer #(
    parameter int unsigned SETTLE_CYC     = 25_000_000,
    parameter int unsigned OPEN_HOLD_CYC  = 500_000_000,
    parameter int unsigned BEEP_CYC       = 10_000_000,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYC    = 1_500_000_000,
    parameter int unsigned ALARM_HALF_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_open,
    input  logic       cmd_close,
    input  logic       auth_fail,
    output logic       pos_sel,
    output logic       buzzer,
    output logic       busy,
    output logic       lockout,
    output logic [2:0] state_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(SETTLE_CYC, OPEN_HOLD_CYC),
                                                max2(BEEP_CYC, LOCKOUT_CYC)), ALARM_HALF_CYC);
    localparam int TW = $clog2(MAX_CYC) + 1;
    localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST    = TW'(OPEN_HOLD_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] HALF_LAST    = TW'(ALARM_HALF_CYC - 1);
    localparam logic [TW-1:0] BEEP_LEN     = TW'(BEEP_CYC);
    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAIL - 1);

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    // Beep cycles remaining outside LOCKOUT; alarm half-period phase inside it.
    logic [TW-1:0] buz_cnt, buz_cnt_n;
    logic [FW-1:0] fail_cnt, fail_cnt_n;
    logic          buzzer_n;

    always_comb begin
        state_n    = state;
        tmr_n      = tmr + TW'(1);
        fail_cnt_n = fail_cnt;
        case (state)
            LOCKED: begin
                if (cmd_open) begin
                    state_n    = OPENING;
                    fail_cnt_n = '0;
                end else if (auth_fail) begin
                    if (fail_cnt >= FAIL_LAST) begin
                        state_n    = LOCKOUT;
                        fail_cnt_n = '0;
                    end else begin
                        fail_cnt_n = fail_cnt + FW'(1);
                    end
                end
            end
            OPENING: if (tmr == SETTLE_LAST) state_n = OPEN;
            OPEN: begin
                if (cmd_close)              state_n = CLOSING;
                else if (cmd_open)          tmr_n   = '0;
                else if (tmr == HOLD_LAST)  state_n = CLOSING;
            end
            CLOSING: if (tmr == SETTLE_LAST)  state_n = LOCKED;
            LOCKOUT: if (tmr == LOCKOUT_LAST) state_n = LOCKED;
            default: state_n = LOCKED;
        endcase
        if (state_n != state) tmr_n = '0;

        buz_cnt_n = '0;
        buzzer_n  = 1'b0;
        if (state_n == LOCKOUT) begin
            if (state != LOCKOUT) begin
                buzzer_n = 1'b1;
            end else if (buz_cnt == HALF_LAST) begin
                buzzer_n = ~buzzer;
            end else begin
                buz_cnt_n = buz_cnt + TW'(1);
                buzzer_n  = buzzer;
            end
        end else if (state != LOCKOUT) begin
            if (state_n != state && (state_n == OPENING || state_n == CLOSING))
                buz_cnt_n = BEEP_LEN;
            else if (buz_cnt != '0)
                buz_cnt_n = buz_cnt - TW'(1);
            buzzer_n = (buz_cnt_n != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOCKED;
            tmr      <= '0;
            buz_cnt  <= '0;
            fail_cnt <= '0;
            pos_sel  <= 1'b0;
            buzzer   <= 1'b0;
            busy     <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            buz_cnt  <= buz_cnt_n;
            fail_cnt <= fail_cnt_n;
            pos_sel  <= (state_n == OPENING) || (state_n == OPEN);
            buzzer   <= buzzer_n;
            busy     <= (state_n == OPENING) || (state_n == CLOSING) || (state_n == LOCKOUT);
            lockout  <= (state_n == LOCKOUT);
        end
    end

    assign state_o = state;

endmodule
